// File: rtl/hawk_att_lkup.sv
// hawk_att_lkup: single-outstanding ATT lookup.
// Takes a host page number and maps it to an ATT entry index. It reads the
// 64-byte ATT block that holds the entry with one single-beat AXI read, then
// decodes the 8-byte AttEntry into a translation packet.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   lkup_*                  request handshake: hppa page number, zero-block-write flag
//   ar_*                    AXI read-address channel (single beat, len 0)
//   r_*                     AXI read-data channel
//   trnsl_*                 translation result: ppa, status, allow, zpd update, error, entry id
module hawk_att_lkup #(
  parameter int unsigned           ADDR_W    = 64,
  parameter int unsigned           DATA_W    = 512,
  parameter logic [ADDR_W-1:0]     ATT_START = 64'hFFF6100000,
  parameter logic [ADDR_W-1:0]     HPPA_BASE = 64'hFFF6400000,
  parameter int unsigned           ENTRY_CNT = 8,
  parameter bit                    BYTESWAP  = 1'b1,
  localparam int unsigned          EID_W     = (ENTRY_CNT > 1) ? $clog2(ENTRY_CNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lkup_valid_i,
  output logic                 lkup_ready_o,
  input  logic [ADDR_W-13:0]   lkup_hppa_i,
  input  logic                 lkup_zeroblkwr_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [ADDR_W-1:0]    ar_addr_o,
  output logic [7:0]           ar_len_o,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  input  logic [DATA_W-1:0]    r_data_i,
  input  logic [1:0]           r_resp_i,
  input  logic                 r_last_i,
  output logic                 trnsl_valid_o,
  input  logic                 trnsl_ready_i,
  output logic [ADDR_W-1:0]    trnsl_ppa_o,
  output logic [1:0]           trnsl_sts_o,
  output logic                 trnsl_allow_o,
  output logic                 trnsl_zpd_update_o,
  output logic [7:0]           trnsl_zpd_cnt_o,
  output logic                 trnsl_err_o,
  output logic [EID_W-1:0]     trnsl_eid_o
);

  localparam int unsigned PG_W = ADDR_W - 12;

  typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;

  state_t              state;
  logic                lkup_ready_q;
  logic                ar_valid_q;
  logic                r_ready_q;
  logic                trnsl_valid_q;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [63:0]         entry_q;
  logic [EID_W-1:0]    eid_q;
  logic [2:0]          slot_q;
  logic                err_q;
  logic                zbw_q;

  logic [PG_W-1:0]     idx_w;
  logic                idx_oor;
  logic [ADDR_W-1:0]   blk_addr;
  logic [63:0]         beat_raw;
  logic [63:0]         beat_entry;

  function automatic logic [63:0] byte_rev(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      o[8*i +: 8] = v[8*(7-i) +: 8];
    end
    return o;
  endfunction

  // Below-base pages wrap to huge indices, so one unsigned compare covers both ends.
  always_comb begin
    idx_w    = lkup_hppa_i - HPPA_BASE[ADDR_W-1:12];
    idx_oor  = (idx_w >= PG_W'(ENTRY_CNT));
    blk_addr = ATT_START + (ADDR_W'(idx_w >> 3) << 6);
  end

  always_comb begin
    beat_raw   = r_data_i[{slot_q, 6'b000000} +: 64];
    beat_entry = BYTESWAP ? byte_rev(beat_raw) : beat_raw;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      lkup_ready_q  <= 1'b1;
      ar_valid_q    <= 1'b0;
      r_ready_q     <= 1'b0;
      trnsl_valid_q <= 1'b0;
      ar_addr_q     <= '0;
      entry_q       <= '0;
      eid_q         <= '0;
      slot_q        <= '0;
      err_q         <= 1'b0;
      zbw_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lkup_valid_i) begin
            lkup_ready_q <= 1'b0;
            zbw_q        <= lkup_zeroblkwr_i;
            eid_q        <= idx_w[EID_W-1:0];
            slot_q       <= idx_w[2:0];
            // Cleared so an out-of-range response decodes to sts=0, ppa=0, zpd=0.
            entry_q      <= '0;
            if (idx_oor) begin
              err_q         <= 1'b1;
              trnsl_valid_q <= 1'b1;
              state         <= RSP;
            end else begin
              err_q      <= 1'b0;
              ar_addr_q  <= blk_addr;
              ar_valid_q <= 1'b1;
              state      <= AR;
            end
          end
        end
        AR: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= R;
          end
        end
        R: begin
          if (r_valid_i) begin
            entry_q <= beat_entry;
            err_q   <= err_q | (r_resp_i != 2'b00);
            if (r_last_i) begin
              r_ready_q     <= 1'b0;
              trnsl_valid_q <= 1'b1;
              state         <= RSP;
            end
          end
        end
        RSP: begin
          if (trnsl_ready_i) begin
            trnsl_valid_q <= 1'b0;
            lkup_ready_q  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decode straight from captured registers; they only change outside RSP,
  // so the packet is stable for the whole response handshake.
  logic [1:0] sts;
  logic [7:0] zpd;
  logic       zpd_upd;

  always_comb begin
    sts     = entry_q[1:0];
    zpd     = entry_q[63:56];
    zpd_upd = zbw_q & (sts == 2'b01) & ~err_q;
  end

  assign lkup_ready_o       = lkup_ready_q;
  assign ar_valid_o         = ar_valid_q;
  assign ar_addr_o          = ar_addr_q;
  assign ar_len_o           = '0;
  assign r_ready_o          = r_ready_q;
  assign trnsl_valid_o      = trnsl_valid_q;
  assign trnsl_ppa_o        = {entry_q[ADDR_W-11:2], 12'h000};
  assign trnsl_sts_o        = sts;
  assign trnsl_allow_o      = sts[0] & ~err_q;
  assign trnsl_zpd_update_o = zpd_upd;
  assign trnsl_zpd_cnt_o    = zpd_upd ? ((zpd == 8'hFF) ? 8'hFF : zpd + 8'd1) : zpd;
  assign trnsl_err_o        = err_q;
  assign trnsl_eid_o        = eid_q;

  // Entry bits between the page field and the zpd count carry no meaning here.
  logic unused_entry_bits;
  assign unused_entry_bits = ^entry_q[55:ADDR_W-10];

endmodule
